// File: rtl/seq_detector_pkg.sv
// Shared constants for the serial pattern detector and its users.
// The default pattern is also exported so the lab top-level and the bench use the same value.
package seq_detector_pkg;

  localparam int          DEF_PAT_LEN = 4;
  localparam logic [3:0]  PAT_1101    = 4'b1101;
  localparam logic [3:0]  DEF_PATTERN = PAT_1101;
  localparam int          DEF_CNT_W   = 4;

  // Bits needed to hold a fill count in the range 0..pat_len
  function automatic int fill_width(input int pat_len);
    return $clog2(pat_len + 1);
  endfunction

endpackage

// File: rtl/seq_detector_sat_counter.sv
// Up-counter that pins at all-ones instead of wrapping.
// It has an asynchronous active-low reset and a synchronous clear.
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  logic [W-1:0] cnt_r;

  // Count on inc, hold at all-ones, clear has priority over inc
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (inc && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign q = cnt_r;

endmodule

// File: rtl/seq_detector.sv
// Serial pattern monitor: shifts in qualified bits, flags overlapping matches with a
// registered one-cycle hit pulse and keeps a saturating match count.
module seq_detector
  import seq_detector_pkg::*;
#(
  parameter int                 PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN,
  parameter int                 CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clr,
  output logic             hit,
  output logic [CNT_W-1:0] hit_cnt,
  output logic             armed
);

  localparam int                FILL_W    = fill_width(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_GATE = FILL_W'(PAT_LEN - 1);

  logic [PAT_LEN-1:0] history_r;
  logic [FILL_W-1:0]  fill_r;
  logic               hit_r;
  logic               armed_r;

  logic [PAT_LEN-1:0] window_s;
  logic [FILL_W-1:0]  fill_nxt_s;
  logic               accept_s;
  logic               match_s;

  // Next window, saturating fill and match decision for the bit on the inputs now.
  // The fill gate keeps reset zeros from matching patterns that begin with zeros.
  always_comb begin
    window_s = {history_r[PAT_LEN-2:0], in_bit};
    accept_s = in_valid & ~clr;
    if (fill_r == FILL_MAX) begin
      fill_nxt_s = fill_r;
    end else begin
      fill_nxt_s = fill_r + FILL_W'(1);
    end
    if (accept_s && (window_s == PATTERN) && (fill_r >= FILL_GATE)) begin
      match_s = 1'b1;
    end else begin
      match_s = 1'b0;
    end
  end

  // Detector state; idle cycles hold history and fill so gaps never break a partial match
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      history_r <= '0;
      fill_r    <= '0;
      hit_r     <= 1'b0;
      armed_r   <= 1'b0;
    end else if (clr) begin
      history_r <= '0;
      fill_r    <= '0;
      hit_r     <= 1'b0;
      armed_r   <= 1'b0;
    end else if (in_valid) begin
      history_r <= window_s;
      fill_r    <= fill_nxt_s;
      hit_r     <= match_s;
      armed_r   <= (fill_nxt_s == FILL_MAX);
    end else begin
      history_r <= history_r;
      fill_r    <= fill_r;
      hit_r     <= 1'b0;
      armed_r   <= armed_r;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_hit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (match_s),
    .q     (hit_cnt)
  );

  assign hit   = hit_r;
  assign armed = armed_r;

endmodule
